// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Buffers ALU operation requests in a small FIFO and issues them one at a
//   time to a combinational ALU from registered operands. The result and zero
//   flag are captured one cycle after issue and returned with the request tag.
//
// Ports
//   clk, rst_n        : clock, synchronous active-low reset
//   req_*             : request channel (valid/ready), operands, op code, tag
//   alu_in1/2, alu_control : registered drive to the ALU
//   alu_result, alu_zero   : ALU outputs, sampled one cycle after issue
//   rsp_*             : response channel (valid/ready), result, zero, tag
//   fifo_count        : request FIFO occupancy
//   busy              : work in flight or queued
module alu_op_sequencer #(
    parameter int DATA_W     = 32,
    parameter int CTRL_W     = 4,
    parameter int TAG_W      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic [DATA_W-1:0]               req_a,
    input  logic [DATA_W-1:0]               req_b,
    input  logic [CTRL_W-1:0]               req_op,
    input  logic [TAG_W-1:0]                req_tag,
    output logic [DATA_W-1:0]               alu_in1,
    output logic [DATA_W-1:0]               alu_in2,
    output logic [CTRL_W-1:0]               alu_control,
    input  logic [DATA_W-1:0]               alu_result,
    input  logic                            alu_zero,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [DATA_W-1:0]               rsp_result,
    output logic                            rsp_zero,
    output logic [TAG_W-1:0]                rsp_tag,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic                            busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [CTRL_W-1:0] op;
        logic [TAG_W-1:0]  tag;
    } entry_t;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state, state_next;
    entry_t            mem [FIFO_DEPTH];
    entry_t            head;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [TAG_W-1:0]  cur_tag;
    logic              push, pop, capture, rsp_clr;

    // Full means no push, even if the same edge pops: there is no bypass.
    assign req_ready  = (count != CNT_W'(FIFO_DEPTH));
    assign push       = req_valid && req_ready;
    assign head       = mem[rd_ptr];
    assign fifo_count = count;
    assign busy       = (state != IDLE) || (count != '0);

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        capture    = 1'b0;
        rsp_clr    = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop        = 1'b1;
                    state_next = EXEC;
                end
            end
            // ALU has had a full cycle on registered operands; sample it now.
            EXEC: begin
                capture    = 1'b1;
                state_next = RESP;
            end
            // A stalled response blocks further pops.
            RESP: begin
                if (rsp_ready) begin
                    rsp_clr = 1'b1;
                    if (count != '0) begin
                        pop        = 1'b1;
                        state_next = EXEC;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            alu_in1     <= '0;
            alu_in2     <= '0;
            alu_control <= '0;
            cur_tag     <= '0;
            rsp_valid   <= 1'b0;
            rsp_result  <= '0;
            rsp_zero    <= 1'b0;
            rsp_tag     <= '0;
        end else begin
            state <= state_next;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
            // ALU drive changes only on a pop and otherwise holds.
            if (pop) begin
                alu_in1     <= head.a;
                alu_in2     <= head.b;
                alu_control <= head.op;
                cur_tag     <= head.tag;
            end
            if (capture) begin
                rsp_valid  <= 1'b1;
                rsp_result <= alu_result;
                rsp_zero   <= alu_zero;
                rsp_tag    <= cur_tag;
            end else if (rsp_clr) begin
                rsp_valid  <= 1'b0;
            end
        end
    end

    // Storage needs no reset: pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (rst_n && push) mem[wr_ptr] <= '{a: req_a, b: req_b, op: req_op, tag: req_tag};
    end

endmodule
